uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between NUM_REQ byte-stream requesters, using round-robin arbitration with message locking.
- Sits between the requesters and the UART top-level `tx_val`/`tx_data`/`busy` interface.
- A granted requester keeps the transmitter until it delivers a byte marked `last`, so messages never interleave on the line.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_W, 2, width of grant index, equal to clog2(NUM_REQ)
START_TO, 1023, max clk cycles to wait for busy rise after tx_val asserts (must be at least 1)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  input  NUM_REQ  per-requester end-of-message marker for the current byte
req_ready  output  NUM_REQ  one-hot, one cycle: byte of requester i accepted
tx_val  output  1  to UART: start transmission
tx_data  output  8  to UART: byte to send
busy  input  1  from UART: transmitter active
grant_valid  output  1  a requester currently owns the transmitter
grant_idx  output  IDX_W  owning requester
err_timeout  output  1  sticky: UART never raised busy; cleared only by reset

Behaviour:
- Reset (rst=0, async): state IDLE, rr_ptr=0, all outputs 0 (req_ready, tx_val, tx_data, grant_valid, grant_idx, err_timeout). A reset mid-byte abandons the byte and the lock; UART state is not touched.
- State IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward, modulo NUM_REQ.
  - Register it into grant_idx, set grant_valid=1, go to LOAD. This takes 1 cycle.
  - If none is set, stay in IDLE.
- State LOAD:
  - If req_valid[grant_idx]=1 and busy=0: latch the byte into tx_data and the last bit into lock_end, pulse req_ready[grant_idx] for this cycle only, and go to START.
  - If busy=1, wait in LOAD; the UART is still finishing.
  - If req_valid[grant_idx]=0, stay in LOAD, keeping the lock for up to the rest of the message (no timeout).
- State START:
  - tx_val=1 and held, with tx_data stable. A timeout counter counts cycles.
  - On busy=1: drop tx_val on the next edge and go to SEND.
  - On count == START_TO with busy still 0: set err_timeout=1, drop tx_val, treat the byte as sent, and go to NEXT.
- State SEND: wait for busy=0, then go to NEXT. tx_data is held.
- State NEXT:
  - If lock_end=0: go to LOAD with the same grant.
  - If lock_end=1: rr_ptr=grant_idx+1, wrapping NUM_REQ-1 to 0; grant_valid=0; go to IDLE.
- Latency: from req_valid in IDLE to tx_val rising is 2 cycles (IDLE→LOAD→START), given busy=0.
- Handshake rules:
  - req_ready is asserted only in the LOAD accept cycle.
  - Requesters hold valid/data/last stable until they see ready.
  - Non-granted requesters never see ready.
- Simultaneous requests are resolved by rr_ptr alone. The owner is never preempted, even if higher-index requesters wait indefinitely.
- tx_val is a level signal held until the UART acknowledges via busy. The UART must sample tx_val only when idle.

Decomposition:
- Shared package `uart_pkg`:
  - state enum: IDLE, LOAD, START, SEND, NEXT
  - DATA_W=8
  - timeout counter width, clog2(START_TO+1)
- One sub-module, `rr_pick`: combinational round-robin priority select taking a req vector and a pointer, returning the found flag and index. It is reused by future RX/command arbiters.

Test Plan:
- Single message: req0 sends 0x55 then 0xA3 with last on the second byte; UART model raises busy 3 cycles after tx_val and holds it 20 cycles → tx_data shows 0x55 then 0xA3, req_ready[0] pulses twice, grant_valid falls after the second busy fall, rr_ptr=1.
- Contention: req0, req2 and req3 all assert a 1-byte message with last=1 at the same time, with rr_ptr=0 → grant order is 0, 2, 3; bytes go out in that order with no interleaving.
- Message lock: req1 sends a 3-byte message 0x01,0x02,0x03 and stalls valid 10 cycles between bytes while req0 is valid → all three req1 bytes finish before req0 is granted; grant_idx stays 1 during the stall.
- Timeout: with START_TO=15, the UART model never raises busy → tx_val stays high exactly 15 cycles, then err_timeout=1 (sticky), req_ready was already pulsed once, and the FSM proceeds; err_timeout stays 1 until rst.
- Reset mid-SEND: assert rst=0 asynchronously while busy=1 and tx_val is already low → outputs clear immediately without waiting for a clock edge. After release with busy still 1, a new request waits in LOAD until busy=0.
- Wrap-around: NUM_REQ=4, rr_ptr=3, req0 and req3 both valid → req3 is granted, then rr_ptr wraps to 0 and req0 is granted next.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART transmit-side arbitration blocks.
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        SEND  = 3'd3,
        NEXT  = 3'd4
    } state_t;

    // The start timeout counter must be able to hold start_to itself.
    function automatic int to_cnt_w(input int start_to);
        return $clog2(start_to + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set bit of req at or above ptr, wrapping modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W:0] pos;

    // Scan from the farthest offset down so the nearest hit to ptr is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (pos >= (IDX_W + 1)'(N)) begin
                pos = pos - (IDX_W + 1)'(N);
            end
            if (req[pos[IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte streams;
// a granted requester keeps the line until it delivers a byte marked last.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int IDX_W    = 2,
    parameter int START_TO = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      tx_val,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      busy,
    output logic                      grant_valid,
    output logic [IDX_W-1:0]          grant_idx,
    output logic                      err_timeout,
    output state_t                    dbg_state
);

    localparam int               CNT_W    = to_cnt_w(START_TO);
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(START_TO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic             lock_end;
    logic [CNT_W-1:0] to_cnt;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             accept;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Handshake: a byte moves when req_valid and req_ready are both high at a clock
    // edge; ready is only ever raised for the owner, in LOAD, while the UART is idle.
    assign accept    = (state == LOAD) && !busy && req_valid[grant_idx];
    assign dbg_state = state;

    always_comb begin
        req_ready            = '0;
        req_ready[grant_idx] = accept;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            lock_end    <= 1'b0;
            to_cnt      <= '0;
            tx_val      <= 1'b0;
            tx_data     <= '0;
            err_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        tx_data  <= req_data[grant_idx*DATA_W +: DATA_W];
                        lock_end <= req_last[grant_idx];
                        tx_val   <= 1'b1;
                        to_cnt   <= CNT_W'(1);
                        state    <= START;
                    end
                end
                START: begin
                    // to_cnt holds the number of cycles tx_val has been high so far.
                    if (busy) begin
                        tx_val <= 1'b0;
                        state  <= SEND;
                    end else if (to_cnt == TO_MAX) begin
                        err_timeout <= 1'b1;
                        tx_val      <= 1'b0;
                        state       <= NEXT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                SEND: begin
                    if (!busy) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (lock_end) begin
                        rr_ptr      <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester drivers, a UART busy model, and a
// scoreboard of expected {grant, byte} pairs checked whenever tx_val rises.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NUM_REQ  = 4;
    localparam int IDX_W    = 2;
    localparam int START_TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [31:0]   req_data;
    logic [3:0]    req_last;
    logic [3:0]    req_ready;
    logic          tx_val;
    logic [7:0]    tx_data;
    logic          busy;
    logic          grant_valid;
    logic [1:0]    grant_idx;
    logic          err_timeout;
    state_t        dbg_state;

    int            checks = 0;
    int            errors = 0;
    int            uart_mode = 0;  // 0 acks after 3 cycles, 1 never acks, 2 busy driven by hand
    logic [9:0]    exp_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .IDX_W    (IDX_W),
        .START_TO (START_TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_val      (tx_val),
        .tx_data     (tx_data),
        .busy        (busy),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .err_timeout (err_timeout),
        .dbg_state   (dbg_state)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] idx, input logic [7:0] d);
        exp_q.push_back({idx, d});
    endtask

    // Presents n bytes on requester idx, holding each until ready, then idles gap cycles.
    task automatic send_msg(input int idx, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input int n, input int gap);
        for (int k = 0; k < n; k++) begin
            int wait_n;
            req_valid[idx]          = 1'b1;
            req_data[idx*8 +: 8]    = (k == 0) ? b0 : (k == 1) ? b1 : b2;
            req_last[idx]           = (k == n - 1);
            #1;
            wait_n = 0;
            while (!req_ready[idx] && wait_n < 600) begin
                @(negedge clk);
                #2;
                wait_n++;
            end
            if (wait_n >= 600) begin
                checks++;
                errors++;
                $display("FAIL ready_wait req=%0d byte=%0d actual=no_ready expected=ready", idx, k);
            end
            @(negedge clk);
            #1;
            req_valid[idx] = 1'b0;
            req_last[idx]  = 1'b0;
            repeat (gap) begin
                @(negedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((dbg_state != IDLE || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, (n < 400), 1);
    endtask

    // UART model: busy rises on the 3rd cycle tx_val is seen high and holds 20 cycles.
    initial begin
        int dly  = 0;
        int hold = 0;
        forever begin
            @(negedge clk);
            if (uart_mode == 2) begin
                dly = 0;
            end else if (busy) begin
                hold--;
                if (hold == 0) busy = 1'b0;
            end else if (tx_val && uart_mode == 0) begin
                dly++;
                if (dly == 3) begin
                    busy = 1'b1;
                    hold = 20;
                    dly  = 0;
                end
            end else begin
                dly = 0;
            end
        end
    end

    // Monitor: ready must go only to the owner of the next expected byte; each tx_val
    // rise must present the next expected {grant_idx, tx_data}.
    initial begin
        logic       prev_tx = 1'b0;
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (req_ready != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    chk("ready_unexpected", req_ready, 0);
                end else begin
                    e = exp_q[0];
                    chk("ready_owner", req_ready, 4'b0001 << e[9:8]);
                end
            end
            if (tx_val && !prev_tx) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected actual=%0h expected=none", {grant_idx, tx_data});
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_byte", {grant_idx, tx_data}, e);
                end
            end
            prev_tx = tx_val;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst       = 1'b0;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        busy      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_tx_val", tx_val, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_grant_valid", grant_valid, 0);
        chk("rst_grant_idx", grant_idx, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_state", dbg_state, IDLE);
        rst = 1'b1;
        @(negedge clk);
        #1;

        // Single two-byte message from req0.
        push(0, 8'h55);
        push(0, 8'hA3);
        fork
            send_msg(0, 8'h55, 8'hA3, 8'h00, 2, 0);
            begin
                @(negedge clk);
                @(negedge clk);
                #1;
                chk("latency_tx_val", tx_val, 1);
                chk("latency_grant_idx", grant_idx, 0);
            end
        join
        n = 0;
        while (!busy && n < 50) begin @(negedge clk); #1; n++; end
        while (busy && n < 100) begin @(negedge clk); #1; n++; end
        chk("msg1_busy_seen", (n < 100), 1);
        chk("msg1_grant_held", grant_valid, 1);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        chk("msg1_grant_release", grant_valid, 0);
        wait_idle("msg1_idle");

        // rr_ptr is now 1: simultaneous req0/req1 must serve req1 first.
        push(1, 8'h11);
        push(0, 8'h10);
        fork
            send_msg(0, 8'h10, 8'h00, 8'h00, 1, 0);
            send_msg(1, 8'h11, 8'h00, 8'h00, 1, 0);
        join
        wait_idle("ptr1_idle");

        rst = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;

        // Contention from rr_ptr 0: order 0, 2, 3.
        push(0, 8'hC0);
        push(2, 8'hC2);
        push(3, 8'hC3);
        fork
            send_msg(0, 8'hC0, 8'h00, 8'h00, 1, 0);
            send_msg(2, 8'hC2, 8'h00, 8'h00, 1, 0);
            send_msg(3, 8'hC3, 8'h00, 8'h00, 1, 0);
        join
        wait_idle("contention_idle");

        // Message lock: req1 stalls between bytes while req0 waits.
        push(1, 8'h01);
        push(1, 8'h02);
        push(1, 8'h03);
        push(0, 8'h0F);
        fork
            send_msg(1, 8'h01, 8'h02, 8'h03, 3, 40);
            begin
                @(negedge clk);
                #1;
                send_msg(0, 8'h0F, 8'h00, 8'h00, 1, 0);
            end
            begin
                n = 0;
                while (!(dbg_state == LOAD && !req_valid[1] && req_valid[0]) && n < 300) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                chk("lock_stall_seen", (n < 300), 1);
                chk("lock_grant_idx", grant_idx, 1);
                chk("lock_grant_valid", grant_valid, 1);
                chk("lock_no_ready", req_ready, 0);
            end
        join
        wait_idle("lock_idle");

        // Start timeout: UART never answers.
        uart_mode = 1;
        push(2, 8'h5A);
        fork
            send_msg(2, 8'h5A, 8'h00, 8'h00, 1, 0);
            begin
                n = 0;
                while (!tx_val && n < 50) begin @(negedge clk); #1; n++; end
                n = 0;
                while (tx_val && n < 100) begin n++; @(negedge clk); #1; end
                chk("timeout_len", n, START_TO);
                chk("timeout_err", err_timeout, 1);
            end
        join
        uart_mode = 0;
        wait_idle("timeout_idle");

        push(1, 8'h3C);
        send_msg(1, 8'h3C, 8'h00, 8'h00, 1, 0);
        wait_idle("sticky_idle");
        chk("err_sticky", err_timeout, 1);

        // Asynchronous reset while the UART is mid-byte.
        uart_mode = 2;
        busy      = 1'b0;
        push(3, 8'h77);
        fork
            send_msg(3, 8'h77, 8'h00, 8'h00, 1, 0);
            begin
                n = 0;
                while (!tx_val && n < 50) begin @(negedge clk); #1; n++; end
                busy = 1'b1;
            end
        join
        @(negedge clk);
        #1;
        chk("send_state", dbg_state, SEND);
        chk("send_tx_val_low", tx_val, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("async_state", dbg_state, IDLE);
        chk("async_grant_valid", grant_valid, 0);
        chk("async_tx_data", tx_data, 0);
        chk("async_err_timeout", err_timeout, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        push(1, 8'h99);
        fork
            send_msg(1, 8'h99, 8'h00, 8'h00, 1, 0);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    #1;
                    chk("busy_wait_state", dbg_state, LOAD);
                    chk("busy_wait_ready", req_ready, 0);
                end
                busy      = 1'b0;
                uart_mode = 0;
            end
        join
        wait_idle("post_reset_idle");

        // Wrap-around: bring rr_ptr to 3, then req0 and req3 together.
        push(2, 8'h12);
        send_msg(2, 8'h12, 8'h00, 8'h00, 1, 0);
        wait_idle("wrap_prep_idle");
        push(3, 8'hE3);
        push(0, 8'hE0);
        fork
            send_msg(0, 8'hE0, 8'h00, 8'h00, 1, 0);
            send_msg(3, 8'hE3, 8'h00, 8'h00, 1, 0);
        join
        wait_idle("wrap_idle");

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
